ma_diversity_reader: RTL
========================

Name: ma_diversity_reader

Overview:
- Reader/collector at the far end of the shared tri-state output line driven by NUM_MA micro-architecture instances.
- For each input vector, the block:
  - drives the 4-bit vector {a0,b0,c0,d0} to all instances;
  - enables one instance's tri-buffer at a time and samples the shared line;
  - compares each response against the golden function y0 = ((a0|b0)&c0) | (d0&(c0|b0)).
- Accumulates error, common-mode and disagreement counts for the HPS-side diversity estimate.

Parameters:
- NUM_MA, 2, number of micro-architecture instances on the shared line (2..8).
- SETTLE_CYC, 2, cycles each enable is held before sampling (>=1).
- VEC_W, 4, input-vector width; fixed bit map vec[3]=a0, vec[2]=b0, vec[1]=c0, vec[0]=d0.
- CNT_W, 5, counter width (VEC_W+1, holds 2^VEC_W).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  begin sweep; accepted only in IDLE.
- vec_out  output  VEC_W  vector driven to all instances.
- tri_en  output  NUM_MA  one-hot-or-zero enables, one per instance tri-buffer.
- bus_y  input  1  shared tri-state line.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse, sweep complete.
- err_cnt  output  CNT_W  vectors where at least one instance != golden.
- common_cnt  output  CNT_W  vectors where all instances agree and != golden.
- disagree_cnt  output  CNT_W  vectors where instances differ among themselves.

Behaviour:
- Reset (async, rst_n=0): state IDLE; vec_out=0, tri_en=0, busy=0, done=0, all counters=0, capture register cleared.
- States:
  - IDLE: on start=1, clear counters, set vec=0 and k=0, go to GAP; busy=1 from the next edge.
  - GAP: 1 cycle, tri_en=0 (break-before-make), then go to DRIVE.
  - DRIVE: tri_en[k]=1 for SETTLE_CYC cycles. In the last DRIVE cycle, capture resp[k]=bus_y at the clock edge. If k<NUM_MA-1, then k++ and go to GAP; else go to COMPARE.
  - COMPARE: 1 cycle, tri_en=0. Update counters. If vec=2^VEC_W-1, go to FINISH; else vec++, k=0, go to GAP.
  - FINISH: done=1 for exactly one cycle, busy=0, counters hold, return to IDLE.
- Enables:
  - tri_en is never multi-hot.
  - tri_en is all-zero in IDLE, GAP, COMPARE and FINISH.
- vec_out changes only on the COMPARE->GAP edge, so it is stable throughout all enables for a vector.
- Counter rules, per vector:
  - err_cnt += (any resp[k] != golden).
  - common_cnt += (all resp equal AND resp[0] != golden).
  - disagree_cnt += (not all resp equal).
  - All are unsigned; they cannot overflow because CNT_W >= VEC_W+1.
- Timing: busy cycles per sweep = 2^VEC_W * (NUM_MA*(1+SETTLE_CYC) + 1). Defaults give 16*7 = 112.
- Boundary conditions:
  - start while busy: ignored.
  - start in the FINISH cycle: ignored.
  - start held high: a new sweep begins on the cycle after FINISH (IDLE sees it).
  - Counters hold their values after done until the next accepted start.
  - rst_n low mid-sweep: immediate return to reset values; tri_en drops asynchronously (no bus contention).
- bus_y sampled as X/Z (undriven) is treated as a mismatch. The bench must never rely on this.

Optional Feature:
- Macro: MA_FIRST_FAIL_LOG_EN.
- Defined:
  - Adds outputs first_fail_vld (1), first_fail_vec (VEC_W) and first_fail_resp (NUM_MA).
  - On the first COMPARE of a sweep with err_cnt increment: latch vec and resp, set first_fail_vld=1.
  - Later failures do not overwrite.
  - All three cleared on reset and on accepted start.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Two instances of a0&d0&(b0|c0) (ma_1 function), defaults, start pulse -> done 112 cycles later; err_cnt=6, common_cnt=6, disagree_cnt=0.
- One ma_1-function instance + one golden-function instance -> err_cnt=6, common_cnt=0, disagree_cnt=6. With MA_FIRST_FAIL_LOG_EN: first_fail_vec=4'b0011, first_fail_resp=2'b10 (bit k = instance k, instance 0 = ma_1-function).
- Two golden instances -> all counters 0; tri_en never multi-hot; GAP cycle with tri_en=0 between every enable.
- start re-pulsed at cycle 40 of a sweep -> ignored; done still at cycle 112; counts unchanged.
- rst_n low at cycle 50 for 2 cycles -> tri_en=0, busy=0, counters=0 immediately; fresh start gives full correct results.
- NUM_MA=3, SETTLE_CYC=1 -> sweep = 16*(3*2+1) = 112 busy cycles; enables cycle 001->010->100 per vector.

Source files
------------

// File: rtl/ma_diversity_reader_if.sv
// Bundle of start/status, vector, enable, shared-line and counter signals for ma_diversity_reader.
// The first-fail log signals exist only when MA_FIRST_FAIL_LOG_EN is defined.
`timescale 1ns/1ps
interface ma_diversity_reader_if #(
    parameter int NUM_MA = 2,
    parameter int VEC_W  = 4,
    parameter int CNT_W  = 5
);
    logic              start;
    logic [VEC_W-1:0]  vec_out;
    logic [NUM_MA-1:0] tri_en;
    logic              bus_y;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  common_cnt;
    logic [CNT_W-1:0]  disagree_cnt;
`ifdef MA_FIRST_FAIL_LOG_EN
    logic              first_fail_vld;
    logic [VEC_W-1:0]  first_fail_vec;
    logic [NUM_MA-1:0] first_fail_resp;

    modport master (
        input  start, bus_y,
        output vec_out, tri_en, busy, done, err_cnt, common_cnt, disagree_cnt,
        output first_fail_vld, first_fail_vec, first_fail_resp
    );
    modport slave (
        output start, bus_y,
        input  vec_out, tri_en, busy, done, err_cnt, common_cnt, disagree_cnt,
        input  first_fail_vld, first_fail_vec, first_fail_resp
    );
`else
    modport master (
        input  start, bus_y,
        output vec_out, tri_en, busy, done, err_cnt, common_cnt, disagree_cnt
    );
    modport slave (
        output start, bus_y,
        input  vec_out, tri_en, busy, done, err_cnt, common_cnt, disagree_cnt
    );
`endif
endinterface

// File: rtl/ma_diversity_reader.sv
// Sweeps all input vectors, polls each micro-architecture instance on the shared line in turn and
// counts errors, common-mode failures and disagreements. Optional first-fail log: MA_FIRST_FAIL_LOG_EN.
`timescale 1ns/1ps
module ma_diversity_reader #(
    parameter int NUM_MA     = 2,
    parameter int SETTLE_CYC = 2,
    parameter int VEC_W      = 4,
    parameter int CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ma_diversity_reader_if.master bus
);
    localparam int K_W = (NUM_MA > 1) ? $clog2(NUM_MA) : 1;
    localparam int S_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [K_W-1:0]   K_LAST = K_W'(NUM_MA - 1);
    localparam logic [S_W-1:0]   S_LAST = S_W'(SETTLE_CYC - 1);
    localparam logic [VEC_W-1:0] V_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_DRIVE,
        S_COMPARE,
        S_FINISH
    } state_t;

    // Reference response; vector bit map is {a0,b0,c0,d0}.
    function automatic logic golden_y(input logic [VEC_W-1:0] v);
        logic a, b, c, d;
        a = v[3];
        b = v[2];
        c = v[1];
        d = v[0];
        return ((a | b) & c) | (d & (c | b));
    endfunction

    state_t            r_state;
    logic [VEC_W-1:0]  r_vec;
    logic [K_W-1:0]    r_k;
    logic [S_W-1:0]    r_settle;
    logic [NUM_MA-1:0] r_resp;
    logic [NUM_MA-1:0] r_tri_en;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  r_common_cnt;
    logic [CNT_W-1:0]  r_disagree_cnt;
`ifdef MA_FIRST_FAIL_LOG_EN
    logic              r_ff_vld;
    logic [VEC_W-1:0]  r_ff_vec;
    logic [NUM_MA-1:0] r_ff_resp;
`endif

    logic w_gold;
    logic w_any_err;
    logic w_all_eq;
    logic w_common;

    assign w_gold    = golden_y(r_vec);
    assign w_any_err = |(r_resp ^ {NUM_MA{w_gold}});
    assign w_all_eq  = (&r_resp) | ~(|r_resp);
    assign w_common  = w_all_eq & (r_resp[0] ^ w_gold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_vec          <= '0;
            r_k            <= '0;
            r_settle       <= '0;
            r_resp         <= '0;
            r_tri_en       <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err_cnt      <= '0;
            r_common_cnt   <= '0;
            r_disagree_cnt <= '0;
`ifdef MA_FIRST_FAIL_LOG_EN
            r_ff_vld       <= 1'b0;
            r_ff_vec       <= '0;
            r_ff_resp      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done   <= 1'b0;
                    r_tri_en <= '0;
                    if (bus.start) begin
                        r_state        <= S_GAP;
                        r_busy         <= 1'b1;
                        r_vec          <= '0;
                        r_k            <= '0;
                        r_settle       <= '0;
                        r_resp         <= '0;
                        r_err_cnt      <= '0;
                        r_common_cnt   <= '0;
                        r_disagree_cnt <= '0;
`ifdef MA_FIRST_FAIL_LOG_EN
                        r_ff_vld       <= 1'b0;
                        r_ff_vec       <= '0;
                        r_ff_resp      <= '0;
`endif
                    end
                end
                // Break-before-make: the enable for instance k only rises after a dead cycle.
                S_GAP: begin
                    r_tri_en <= NUM_MA'(1) << r_k;
                    r_settle <= '0;
                    r_state  <= S_DRIVE;
                end
                S_DRIVE: begin
                    if (r_settle == S_LAST) begin
                        r_resp[r_k] <= bus.bus_y;
                        r_tri_en    <= '0;
                        if (r_k == K_LAST) begin
                            r_state <= S_COMPARE;
                        end else begin
                            r_k     <= r_k + K_W'(1);
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_settle <= r_settle + S_W'(1);
                    end
                end
                S_COMPARE: begin
                    r_tri_en <= '0;
                    if (w_any_err) r_err_cnt <= r_err_cnt + CNT_W'(1);
                    if (w_common) r_common_cnt <= r_common_cnt + CNT_W'(1);
                    if (!w_all_eq) r_disagree_cnt <= r_disagree_cnt + CNT_W'(1);
`ifdef MA_FIRST_FAIL_LOG_EN
                    if (w_any_err && !r_ff_vld) begin
                        r_ff_vld  <= 1'b1;
                        r_ff_vec  <= r_vec;
                        r_ff_resp <= r_resp;
                    end
`endif
                    if (r_vec == V_LAST) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_vec   <= r_vec + VEC_W'(1);
                        r_k     <= '0;
                        r_state <= S_GAP;
                    end
                end
                // A start seen here is deliberately dropped; IDLE picks up a held start next cycle.
                S_FINISH: begin
                    r_done   <= 1'b0;
                    r_tri_en <= '0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_tri_en <= '0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec_out      = r_vec;
    assign bus.tri_en       = r_tri_en;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err_cnt      = r_err_cnt;
    assign bus.common_cnt   = r_common_cnt;
    assign bus.disagree_cnt = r_disagree_cnt;
`ifdef MA_FIRST_FAIL_LOG_EN
    assign bus.first_fail_vld  = r_ff_vld;
    assign bus.first_fail_vec  = r_ff_vec;
    assign bus.first_fail_resp = r_ff_resp;
`endif
endmodule
